// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Groups the CPU-facing signals of the multiply/divide sequencer.
//   master : control path / CPU side (drives launches, MT writes, MF reads)
//   slave  : the sequencer (owns HI/LO, reports busy/stall/done)
//   Signals:
//     start_mul, start_div, is_unsigned  launch controls
//     op_a, op_b                         rs / rt operands
//     mthi, mtlo, wdata                  direct HI/LO writes
//     rd_hilo                            current instruction reads HI/LO
//     hi, lo                             architectural HI/LO registers
//     busy, stall, done                  sequencing status
interface muldiv_sequencer_if;
  logic        start_mul;
  logic        start_div;
  logic        is_unsigned;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        rd_hilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output start_mul, start_div, is_unsigned, op_a, op_b,
    output mthi, mtlo, wdata, rd_hilo,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start_mul, start_div, is_unsigned, op_a, op_b,
    input  mthi, mtlo, wdata, rd_hilo,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle multiply/divide controller owning the HI/LO pair.
//   MULT/MULTU run a 32-step shift-add, DIV/DIVU a 32-step restoring divide,
//   both on operand magnitudes; a final FIX cycle applies sign correction and
//   writes HI/LO. While busy, any HI/LO-touching instruction is stalled.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    muldiv_sequencer_if.slave (launch, MT/MF, HI/LO, busy/stall/done)
//   Optional feature macro: MULDIV_FAST_MUL_EN
//     defined   -> multiplies complete combinationally at the launch edge
//     undefined -> multiplies use the iterative sequence
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  muldiv_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through raw.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic uns);
    return (!uns && v[31]) ? neg32(v) : v;
  endfunction

  state_t      state_r;
  logic        is_div_r;
  logic        sign_a_r;
  logic        sign_b_r;
  logic        div_zero_r;
  logic [5:0]  cnt_r;
  logic [31:0] mcand_r;     // multiplicand (mul) or divisor (div) magnitude
  logic [31:0] acc_r;       // upper product accumulator (mul) or remainder (div)
  logic [31:0] low_r;       // multiplier shifting out (mul) or quotient (div)
  logic [31:0] op_a_raw_r;  // dividend as launched, returned on divide by zero
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;

  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_sh_s;
  logic [31:0] acc_next_s;
  logic [31:0] low_next_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;
  logic        launch_seq_s;
  logic        fast_mul_s;
  logic [63:0] fast_prod_s;

  // Launch decode; divide wins a simultaneous launch.
  always_comb begin
    mag_a_s = mag32(bus.op_a, bus.is_unsigned);
    mag_b_s = mag32(bus.op_b, bus.is_unsigned);
`ifdef MULDIV_FAST_MUL_EN
    launch_seq_s = bus.start_div;
    fast_mul_s   = bus.start_mul & ~bus.start_div;
    // Low 64 bits of the product of extended operands equal the signed or
    // unsigned 64-bit product, so one unsigned multiplier serves both.
    fast_prod_s  = (bus.is_unsigned ? {32'd0, bus.op_a} : {{32{bus.op_a[31]}}, bus.op_a})
                 * (bus.is_unsigned ? {32'd0, bus.op_b} : {{32{bus.op_b[31]}}, bus.op_b});
`else
    launch_seq_s = bus.start_div | bus.start_mul;
    fast_mul_s   = 1'b0;
    fast_prod_s  = 64'd0;
`endif
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s = {1'b0, acc_r} + {1'b0, (low_r[0] ? mcand_r : 32'd0)};
    div_sh_s  = {acc_r, low_r[31]};
    if (is_div_r) begin
      if (div_sh_s >= {1'b0, mcand_r}) begin
        // Difference is below the divisor, so the low 32 bits are exact.
        acc_next_s = div_sh_s[31:0] - mcand_r;
        low_next_s = {low_r[30:0], 1'b1};
      end else begin
        acc_next_s = div_sh_s[31:0];
        low_next_s = {low_r[30:0], 1'b0};
      end
    end else begin
      acc_next_s = mul_sum_s[32:1];
      low_next_s = {mul_sum_s[0], low_r[31:1]};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = ~{acc_r, low_r} + 64'd1;
    end else begin
      prod_fix_s = {acc_r, low_r};
    end
    if (div_zero_r) begin
      quot_fix_s = 32'hFFFF_FFFF;
      rem_fix_s  = op_a_raw_r;
    end else begin
      quot_fix_s = (sign_a_r ^ sign_b_r) ? neg32(low_r) : low_r;
      rem_fix_s  = sign_a_r ? neg32(acc_r) : acc_r;
    end
  end

  // Sequencer FSM with HI/LO ownership and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      is_div_r   <= 1'b0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
      cnt_r      <= 6'd0;
      mcand_r    <= 32'd0;
      acc_r      <= 32'd0;
      low_r      <= 32'd0;
      op_a_raw_r <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (launch_seq_s) begin
            state_r    <= RUN;
            busy_r     <= 1'b1;
            cnt_r      <= 6'd0;
            is_div_r   <= bus.start_div;
            sign_a_r   <= ~bus.is_unsigned & bus.op_a[31];
            sign_b_r   <= ~bus.is_unsigned & bus.op_b[31];
            div_zero_r <= bus.start_div & (bus.op_b == 32'd0);
            op_a_raw_r <= bus.op_a;
            acc_r      <= 32'd0;
            mcand_r    <= bus.start_div ? mag_b_s : mag_a_s;
            low_r      <= bus.start_div ? mag_a_s : mag_b_s;
          end else if (fast_mul_s) begin
            hi_r   <= fast_prod_s[63:32];
            lo_r   <= fast_prod_s[31:0];
            done_r <= 1'b1;
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          low_r <= low_next_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_CNT) state_r <= FIX;
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quot_fix_s;
          end else begin
            hi_r <= prod_fix_s[63:32];
            lo_r <= prod_fix_s[31:0];
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  // Stall must act in the same cycle the HI/LO access is decoded.
  assign bus.stall = busy_r & (bus.rd_hilo | bus.start_mul | bus.start_div | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer: directed cases plus randomized
//   operations compared against a plain-arithmetic reference model.
//   Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  muldiv_sequencer_if bus_if();

  muldiv_sequencer #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Free-running clock, 10 time units period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {HI, LO} from ordinary integer arithmetic.
  function automatic logic [63:0] model(input bit is_div, input bit uns,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] res;
    if (uns) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = $signed(a);
      sb = $signed(b);
    end
    if (!is_div) begin
      res = 64'(sa * sb);
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus_if.done) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_op(input string tag, input bit is_div, input bit uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit both, input bit mt);
    logic [63:0] exp;
    logic [63:0] old;
    int          busy_cnt;
    int          exp_busy;
    bit          seen;
    bit          hold_bad;
    exp      = model(is_div, uns, a, b);
    exp_busy = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) exp_busy = 0;
`endif
    @(negedge clk);
    old                = {bus_if.hi, bus_if.lo};
    bus_if.start_div   = is_div;
    bus_if.start_mul   = !is_div || both;
    bus_if.is_unsigned = uns;
    bus_if.op_a        = a;
    bus_if.op_b        = b;
    bus_if.mthi        = mt;
    bus_if.mtlo        = mt;
    bus_if.wdata       = 32'h1234_5678;
    @(negedge clk);
    bus_if.start_div   = 1'b0;
    bus_if.start_mul   = 1'b0;
    bus_if.mthi        = 1'b0;
    bus_if.mtlo        = 1'b0;
    bus_if.op_a        = $urandom;
    bus_if.op_b        = $urandom;
    bus_if.is_unsigned = 1'($urandom);
    busy_cnt = 0;
    seen     = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus_if.done) begin
        seen = 1'b1;
      end else begin
        if (bus_if.busy) busy_cnt++;
        if (bus_if.busy && ({bus_if.hi, bus_if.lo} !== old)) hold_bad = 1'b1;
        @(negedge clk);
      end
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_hilo"}, {bus_if.hi, bus_if.lo}, exp);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check_eq({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check_eq({tag, "_busy_low"}, 64'(bus_if.busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
  endtask

  initial begin
    logic [63:0] old;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rdiv;
    bit          runs;

    reset              = 1'b1;
    bus_if.start_mul   = 1'b0;
    bus_if.start_div   = 1'b0;
    bus_if.is_unsigned = 1'b0;
    bus_if.op_a        = 32'd0;
    bus_if.op_b        = 32'd0;
    bus_if.mthi        = 1'b0;
    bus_if.mtlo        = 1'b0;
    bus_if.wdata       = 32'd0;
    bus_if.rd_hilo     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    check_eq("rst_busy", 64'(bus_if.busy), 64'd0);
    check_eq("rst_done", 64'(bus_if.done), 64'd0);
    reset = 1'b0;
    bus_if.rd_hilo = 1'b1;
    #1 check_eq("idle_stall", 64'(bus_if.stall), 64'd0);
    bus_if.rd_hilo = 1'b0;

    // MTHI/MTLO in IDLE
    @(negedge clk);
    bus_if.mthi = 1'b1; bus_if.mtlo = 1'b1; bus_if.wdata = 32'hCAFE_0001;
    @(negedge clk);
    bus_if.mthi = 1'b0; bus_if.mtlo = 1'b1; bus_if.wdata = 32'h0000_0077;
    check_eq("mt_both", {bus_if.hi, bus_if.lo}, 64'hCAFE_0001_CAFE_0001);
    @(negedge clk);
    bus_if.mtlo = 1'b0;
    check_eq("mt_lo", {bus_if.hi, bus_if.lo}, 64'hCAFE_0001_0000_0077);

    run_op("multu",  1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2,         1'b0, 1'b0);
    run_op("mult",   1'b0, 1'b0, 32'hFFFF_FFF9, 32'h3,         1'b0, 1'b0);
    run_op("div",    1'b1, 1'b0, 32'hFFFF_FFF9, 32'h2,         1'b0, 1'b0);
    run_op("divu_mt",1'b1, 1'b1, 32'd100,       32'd7,         1'b0, 1'b1);
    run_op("divu0",  1'b1, 1'b1, 32'd5,         32'd0,         1'b0, 1'b0);
    run_op("div0s",  1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0,         1'b0, 1'b0);
    run_op("divovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("both",   1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7,         1'b1, 1'b0);

    // Stall terms and ignored requests while busy
    @(negedge clk);
    bus_if.start_div = 1'b1; bus_if.is_unsigned = 1'b1;
    bus_if.op_a = 32'd1000;  bus_if.op_b = 32'd3;
    @(negedge clk);
    bus_if.start_div = 1'b0;
    old = {bus_if.hi, bus_if.lo};
    bus_if.wdata = 32'h0000_DEAD;
    for (int t = 0; t < 5; t++) begin
      bus_if.rd_hilo   = (t == 0);
      bus_if.mthi      = (t == 1);
      bus_if.mtlo      = (t == 2);
      bus_if.start_mul = (t == 3);
      bus_if.start_div = (t == 4);
      #1 check_eq($sformatf("stall_term%0d", t), 64'(bus_if.stall), 64'd1);
      @(negedge clk);
      check_eq($sformatf("busy_hold%0d", t), {bus_if.hi, bus_if.lo}, old);
    end
    bus_if.rd_hilo = 1'b0; bus_if.mthi = 1'b0; bus_if.mtlo = 1'b0;
    bus_if.start_mul = 1'b0; bus_if.start_div = 1'b0;
    #1 check_eq("stall_none", 64'(bus_if.stall), 64'd0);
    wait_done("busy_op");
    check_eq("busy_op_hilo", {bus_if.hi, bus_if.lo}, model(1'b1, 1'b1, 32'd1000, 32'd3));

    // Reset in the middle of a run
    @(negedge clk);
    bus_if.start_div = 1'b1; bus_if.is_unsigned = 1'b0;
    bus_if.op_a = 32'd12345; bus_if.op_b = 32'd11;
    @(negedge clk);
    bus_if.start_div = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    check_eq("midrst_busy", 64'(bus_if.busy), 64'd0);
    check_eq("midrst_done", 64'(bus_if.done), 64'd0);
    @(negedge clk);
    check_eq("midrst_idle", 64'(bus_if.busy), 64'd0);
    run_op("after_rst", 1'b0, 1'b0, 32'hFFFF_FF00, 32'h0001_0003, 1'b0, 1'b0);

    // Randomized operations
    for (int k = 0; k < 24; k++) begin
      rdiv = 1'($urandom);
      runs = 1'($urandom);
      ra   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      run_op($sformatf("rnd%0d", k), rdiv, runs, ra, rb, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
